// File: rtl/lock_key_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : lock_key_loader_if
//  Description : Serial key stream handshake between a key source (secure
//                key store / scan port) and the key loader.
//                  key_sdi        serial key bit, LSB first
//                  key_sdi_valid  key_sdi carries a bit this cycle
//                  key_sdi_ready  loader accepts a bit this cycle
//                Modports: master = key source, slave = loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lock_key_loader_if;
  logic key_sdi;
  logic key_sdi_valid;
  logic key_sdi_ready;

  modport master (
    output key_sdi,
    output key_sdi_valid,
    input  key_sdi_ready
  );

  modport slave (
    input  key_sdi,
    input  key_sdi_valid,
    output key_sdi_ready
  );
endinterface
`default_nettype wire

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : lock_key_loader
//  Description : Loads the unlock key of a logic-locked datapath from a
//                serial source. Bits are collected in a shadow register and
//                only committed to key_out once the whole key (and, when
//                LOCK_KEY_PARITY_EN is defined, a trailing even-parity bit)
//                has been received, so the datapath never sees a partial key.
//  Parameters  : KEY_W   - number of key bits (>=1)
//                TIMEOUT - idle cycles allowed between bits before abort (>=1)
//  Macro       : LOCK_KEY_PARITY_EN - adds the CHECK state and parity bit
//  Ports       : clk, rst_n      clock / async active-low reset
//                start           begin a load (honoured in IDLE or ARMED)
//                zeroize         clear committed key, back to IDLE
//                sdi             serial key handshake (slave modport)
//                key_out         committed key to the locked datapath
//                key_loaded      key_out holds a committed key
//                busy            load in progress
//                err             sticky: last load aborted
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_key_loader #(
  parameter int KEY_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                zeroize,
  lock_key_loader_if.slave    sdi,
  output logic [KEY_W-1:0]    key_out,
  output logic                key_loaded,
  output logic                busy,
  output logic                err
);

  localparam int BIT_W = $clog2(KEY_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(KEY_W - 1);
  // The idle edge that would bring the counter to TIMEOUT aborts the load.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ARMED = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [KEY_W-1:0]   r_shadow;
  logic [KEY_W-1:0]   w_shadow_next;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [TMO_W-1:0]   r_tmo;

  logic w_ready;
  logic w_start_load;
  logic w_accept_key;
  logic w_commit;
  logic w_abort;
  logic w_idle_tick;
  logic w_zero;

`ifdef LOCK_KEY_PARITY_EN
  logic w_parity_ok;
  assign w_parity_ok = ~(^r_shadow ^ sdi.key_sdi);
`endif

  assign sdi.key_sdi_ready = w_ready;

  // Shadow with the incoming key bit merged at its position; also used as the
  // commit value so the last bit lands in key_out on its own accept edge.
  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < KEY_W; i++) begin
      if (w_accept_key && (r_bit_cnt == BIT_W'(i))) begin
        w_shadow_next[i] = sdi.key_sdi;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    busy         = 1'b0;
    w_start_load = 1'b0;
    w_accept_key = 1'b0;
    w_commit     = 1'b0;
    w_abort      = 1'b0;
    w_idle_tick  = 1'b0;
    w_zero       = 1'b0;

    case (r_state)
      S_IDLE, S_ARMED: begin
        if (start) begin
          w_next       = S_LOAD;
          w_start_load = 1'b1;
        end
      end

      S_LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (sdi.key_sdi_valid) begin
          w_accept_key = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
`ifdef LOCK_KEY_PARITY_EN
            w_next   = S_CHECK;
`else
            w_commit = 1'b1;
            w_next   = S_ARMED;
`endif
          end
        end else if (r_tmo == TMO_LAST) begin
          w_abort = 1'b1;
          w_next  = S_ERR;
        end else begin
          w_idle_tick = 1'b1;
        end
      end

`ifdef LOCK_KEY_PARITY_EN
      S_CHECK: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (sdi.key_sdi_valid) begin
          if (w_parity_ok) begin
            w_commit = 1'b1;
            w_next   = S_ARMED;
          end else begin
            w_abort = 1'b1;
            w_next  = S_ERR;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_abort = 1'b1;
          w_next  = S_ERR;
        end else begin
          w_idle_tick = 1'b1;
        end
      end
`endif

      S_ERR: begin
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase

    // zeroize overrides everything, including a coincident final accept.
    if (zeroize) begin
      w_next       = S_IDLE;
      w_zero       = 1'b1;
      w_start_load = 1'b0;
      w_accept_key = 1'b0;
      w_commit     = 1'b0;
      w_abort      = 1'b0;
      w_idle_tick  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: shadow, counters and committed key
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_bit_cnt  <= '0;
      r_tmo      <= '0;
      key_out    <= '0;
      key_loaded <= 1'b0;
      err        <= 1'b0;
    end else if (w_zero) begin
      r_shadow   <= '0;
      r_bit_cnt  <= '0;
      r_tmo      <= '0;
      key_out    <= '0;
      key_loaded <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (w_start_load) begin
        r_shadow <= '0;
        err      <= 1'b0;
      end else if (w_abort) begin
        r_shadow <= '0;
      end else if (w_accept_key) begin
        r_shadow <= w_shadow_next;
      end

      // Counters restart on every state entry so they never wrap.
      if (w_next != r_state) begin
        r_bit_cnt <= '0;
        r_tmo     <= '0;
      end else if (w_accept_key) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        r_tmo     <= '0;
      end else if (w_idle_tick) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end

      // Old key stays driven until the new one is complete; an abort revokes it.
      if (w_commit) begin
        key_out    <= w_shadow_next;
        key_loaded <= 1'b1;
      end else if (w_abort) begin
        key_out    <= '0;
        key_loaded <= 1'b0;
        err        <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_key_loader
//  Description : Directed self-checking bench for lock_key_loader with
//                KEY_W=2, TIMEOUT=4. Expected values are hand-computed; the
//                parity bit is appended when LOCK_KEY_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_key_loader;
  localparam int KEY_W   = 2;
  localparam int TIMEOUT = 4;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             start   = 1'b0;
  logic             zeroize = 1'b0;
  logic [KEY_W-1:0] key_out;
  logic             key_loaded;
  logic             busy;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  lock_key_loader_if sif();

  lock_key_loader #(
    .KEY_W   (KEY_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .zeroize    (zeroize),
    .sdi        (sif.slave),
    .key_out    (key_out),
    .key_loaded (key_loaded),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sif.key_sdi       = b;
    sif.key_sdi_valid = 1'b1;
    tick();
    sif.key_sdi_valid = 1'b0;
  endtask

  task automatic begin_load;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_key(input logic [1:0] k);
    begin_load();
    send_bit(k[0]);
    send_bit(k[1]);
`ifdef LOCK_KEY_PARITY_EN
    send_bit(^k);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sif.key_sdi       = 1'b0;
    sif.key_sdi_valid = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_key_out", key_out, 0);
    chk("rst_loaded", key_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", sif.key_sdi_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", sif.key_sdi_ready, 0);

    // ---------------- 1: load 2'b01 ----------------
    begin_load();
    chk("t1_busy", busy, 1);
    chk("t1_ready", sif.key_sdi_ready, 1);
    send_bit(1'b1);
    chk("t1_mid_loaded", key_loaded, 0);
    send_bit(1'b0);
`ifdef LOCK_KEY_PARITY_EN
    chk("t1_chk_loaded", key_loaded, 0);
    chk("t1_chk_busy", busy, 1);
    send_bit(1'b1);
`endif
    chk("t1_key", key_out, 2'b01);
    chk("t1_loaded", key_loaded, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_ready_done", sif.key_sdi_ready, 0);

`ifdef LOCK_KEY_PARITY_EN
    // ---------------- 2: parity pass / fail ----------------
    load_key(2'b11);
    chk("t2_key_ok", key_out, 2'b11);
    chk("t2_loaded_ok", key_loaded, 1);
    begin_load();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t2_err", err, 1);
    chk("t2_key_revoked", key_out, 0);
    chk("t2_loaded_revoked", key_loaded, 0);
    tick();
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_err", err, 1);
    chk("t2_idle_ready", sif.key_sdi_ready, 0);
`endif

    // ---------------- 4: reload from ARMED ----------------
    load_key(2'b10);
    chk("t4_key_first", key_out, 2'b10);
    begin_load();
    chk("t4_key_hold0", key_out, 2'b10);
    chk("t4_loaded_hold0", key_loaded, 1);
    chk("t4_busy", busy, 1);
    send_bit(1'b1);
    chk("t4_key_hold1", key_out, 2'b10);
    send_bit(1'b1);
`ifdef LOCK_KEY_PARITY_EN
    chk("t4_key_hold2", key_out, 2'b10);
    send_bit(1'b0);
`endif
    chk("t4_key_new", key_out, 2'b11);
    chk("t4_loaded_new", key_loaded, 1);

    // valid while ARMED is ignored
    sif.key_sdi       = 1'b0;
    sif.key_sdi_valid = 1'b1;
    tick();
    sif.key_sdi_valid = 1'b0;
    chk("armed_ignore_key", key_out, 2'b11);
    chk("armed_ready", sif.key_sdi_ready, 0);

    // ---------------- 3: timeout ----------------
    begin_load();
    send_bit(1'b1);
    repeat (3) tick();
    chk("t3_err_pre", err, 0);
    chk("t3_ready_pre", sif.key_sdi_ready, 1);
    tick();
    chk("t3_err", err, 1);
    chk("t3_key", key_out, 0);
    chk("t3_loaded", key_loaded, 0);
    chk("t3_ready", sif.key_sdi_ready, 0);
    tick();
    chk("t3_idle_busy", busy, 0);
    chk("t3_err_sticky", err, 1);
    begin_load();
    chk("t3_err_cleared", err, 0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zero_busy", busy, 0);

    // ---------------- 5: zeroize on final accept ----------------
    load_key(2'b01);
    chk("t5_key_pre", key_out, 2'b01);
    begin_load();
    send_bit(1'b0);
`ifdef LOCK_KEY_PARITY_EN
    send_bit(1'b0);
`endif
    sif.key_sdi       = 1'b1;
    sif.key_sdi_valid = 1'b1;
    zeroize           = 1'b1;
    tick();
    sif.key_sdi_valid = 1'b0;
    zeroize           = 1'b0;
    chk("t5_key", key_out, 0);
    chk("t5_loaded", key_loaded, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", sif.key_sdi_ready, 0);
    tick();
    chk("t5_key_after", key_out, 0);

    // async reset mid-LOAD
    load_key(2'b11);
    chk("t5r_key_pre", key_out, 2'b11);
    begin_load();
    send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5r_key", key_out, 0);
    chk("t5r_loaded", key_loaded, 0);
    chk("t5r_busy", busy, 0);
    chk("t5r_ready", sif.key_sdi_ready, 0);
    chk("t5r_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- 6: throttled source, start ignored in LOAD ----------------
    begin
      logic [2:0] bits;
      int         nbits;
      bits  = 3'b011;
      nbits = KEY_W;
`ifdef LOCK_KEY_PARITY_EN
      nbits = KEY_W + 1;
`endif
      begin_load();
      for (int i = 0; i < nbits; i++) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t6_busy_gap", busy, 1);
        chk("t6_err_gap", err, 0);
        send_bit(bits[i]);
      end
    end
    chk("t6_key", key_out, 2'b11);
    chk("t6_loaded", key_loaded, 1);
    chk("t6_err", err, 0);
    chk("t6_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
- Loads the unlock key for a logic-locked combinational datapath (e.g. a locked adder slice with key_0..key_N inputs) from a serial key source.
- Sequences the load with a valid/ready handshake and optionally checks parity.
- Drives the key bus to the locked datapath only after a complete, verified load.
- Sits between the secure key store / scan interface and the locked netlist's key inputs.

Parameters:
- KEY_W, 2, number of key bits driven to the locked datapath (≥1).
- TIMEOUT, 16, max idle cycles between serial bits while loading before abort (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: begin a key load (ignored unless IDLE or ARMED).
- zeroize  input  1  synchronous clear of committed key, highest priority after reset.
- key_sdi  input  1  serial key bit.
- key_sdi_valid  input  1  key_sdi valid this cycle.
- key_sdi_ready  output  1  loader accepts a bit this cycle.
- key_out  output  KEY_W  committed key to locked datapath key inputs (key_out[i] -> key_i).
- key_loaded  output  1  key_out holds a committed key.
- busy  output  1  load in progress.
- err  output  1  sticky: last load aborted (timeout or parity); cleared by next start or zeroize.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; key_out=0, key_loaded=0, busy=0, err=0, key_sdi_ready=0; shadow register, bit counter and timeout counter = 0.
- States: IDLE, LOAD, CHECK, ARMED, ERR.
- IDLE: key_sdi_ready=0. start -> LOAD; shadow, bit counter and timeout counter cleared; err cleared.
- LOAD:
  - busy=1, key_sdi_ready=1.
  - A bit is accepted when key_sdi_valid&&key_sdi_ready; bits arrive LSB first, and bit k goes to shadow[k].
  - Each accepted bit increments the bit counter and resets the timeout counter. Cycles without a transfer increment the timeout counter.
  - When the timeout counter reaches TIMEOUT: -> ERR.
  - After the KEY_W-th bit is accepted: -> CHECK if parity is enabled, else commit directly. Commit means key_out<=shadow and key_loaded<=1 on the same edge as the last accept; next state ARMED.
- CHECK (parity build only):
  - key_sdi_ready=1; accepts exactly one parity bit under the same timeout rule.
  - Even parity: XOR(shadow, parity bit) must be 0. Pass -> commit, ARMED. Fail -> ERR.
- ARMED:
  - busy=0, key_sdi_ready=0; key_out held stable.
  - start -> LOAD, while the old key_out/key_loaded stay driven until the new commit. The datapath never sees a partial key.
- ERR:
  - err=1 and the shadow register is cleared.
  - key_out<=0, key_loaded<=0 (a failed load revokes any earlier key).
  - Next cycle -> IDLE; err stays 1.
- zeroize (any state):
  - Next edge: key_out=0, key_loaded=0, err=0, shadow cleared, state=IDLE.
  - Wins over start and over a simultaneous last-bit accept; that bit is discarded.
- start while in LOAD/CHECK is ignored.
- key_sdi_valid outside LOAD/CHECK is ignored, since ready=0 there.
- Latency: key_out updates on the edge of the final accepted bit; key_loaded rises on that same edge. Minimum start-to-key_loaded is KEY_W+1 cycles (+1 with parity).
- Counter widths: bit counter clog2(KEY_W+1); timeout counter clog2(TIMEOUT+1). Neither counter wraps: both clear on every state entry.

Optional Feature:
- Macro: LOCK_KEY_PARITY_EN.
- Defined: the CHECK state exists, one trailing even-parity bit is required, and a mismatch goes to ERR.
- Undefined: CHECK is not built and commit happens on the KEY_W-th bit; err is raised only by timeout.

Test Plan:
1. KEY_W=2, no parity: reset, start, send bits 1 then 0 back-to-back -> key_out=2'b01 and key_loaded=1 on the 2nd accept edge; busy=0 the next cycle.
2. Parity build: start, send 1,1, parity 0 -> key_out=2'b11, key_loaded=1. Repeat with parity 1 -> err=1, key_out=0, key_loaded=0, state returns to IDLE.
3. Timeout (TIMEOUT=4): start, send one bit, then hold valid=0 for 4 cycles -> err=1, key_loaded=0, key_sdi_ready drops.
4. Reload from ARMED with key 2'b10 loaded: start, send 1,1 -> key_out stays 2'b10 until the final accept, then becomes 2'b11 with no intermediate value.
5. zeroize on the same cycle as the last accepted bit -> key_out=0, key_loaded=0, state IDLE; an async rst_n pulse mid-LOAD -> all outputs 0 immediately.
6. Throttled source: valid toggling 1/0 with gaps of 3 cycles < TIMEOUT=4 -> load completes with no err.
